// File: rtl/axis_snooper_param_pkg.sv
// Shared state encodings, word geometry helper and saturating-add macro for axis_snooper_param.
// AXSNP_SAT_ADD(acc, inc, w) yields acc+inc clamped to the all-ones value of a w-bit register.
`ifndef AXSNP_SAT_ADD
`define AXSNP_SAT_ADD(acc, inc, w) \
    ((({1'b0, (acc)} + ((w)+1)'(inc)) > {1'b0, {(w){1'b1}}}) ? {(w){1'b1}} : ((acc) + (w)'(inc)))
`endif

package axis_snooper_param_pkg;

    typedef logic [1:0] snoop_state_t;

    localparam snoop_state_t ST_IDLE    = 2'd0;
    localparam snoop_state_t ST_CAPTURE = 2'd1;
    localparam snoop_state_t ST_DISCARD = 2'd2;
    localparam snoop_state_t ST_COMMIT  = 2'd3;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_snooper_param_keep_popcount.sv
// Counts the set bits of a keep vector; used only when per-byte keep is observed.
module keep_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]       keep,
    output logic [$clog2(WIDTH):0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {{($clog2(WIDTH)){1'b0}}, keep[i]};
        end
    end

endmodule

// File: rtl/axis_snooper_param.sv
// Passive AXI Stream snooper: copies accepted packets into packet memory and reports length/truncation.
// Define SNOOP_TKEEP_EN to observe snoop_TKEEP; otherwise every byte of a written beat counts.
module axis_snooper_param
    import axis_snooper_param_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 9,
    parameter int LEN_WIDTH      = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [DATA_WIDTH-1:0]     snoop_TDATA,
`ifdef SNOOP_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0]   snoop_TKEEP,
`endif
    input  logic                      snoop_TVALID,
    input  logic                      snoop_TREADY,
    input  logic                      snoop_TLAST,
    input  logic                      mem_ready,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH/8-1:0]   wr_strb,
    output logic                      wr_en,
    output logic                      done,
    output logic [LEN_WIDTH-1:0]      byte_len,
    output logic                      truncated,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W          = $clog2(BYTES_PER_WORD) + 1;
    localparam logic [LEN_WIDTH-1:0] ZERO_LEN = '0;

    snoop_state_t              state;
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic                      ptr_full;
    logic [LEN_WIDTH-1:0]      acc_len;
    logic                      acc_trunc;
    logic [BYTES_PER_WORD-1:0] keep_vec;
    logic [CNT_W-1:0]          keep_cnt;
    logic                      beat;
    logic                      sop;
    logic                      store;

`ifdef SNOOP_TKEEP_EN
    assign keep_vec = snoop_TKEEP;

    keep_popcount #(
        .WIDTH(BYTES_PER_WORD)
    ) u_keep_popcount (
        .keep  (keep_vec),
        .count (keep_cnt)
    );
`else
    assign keep_vec = '1;
    assign keep_cnt = CNT_W'(BYTES_PER_WORD);
`endif

    // A beat seen in IDLE or COMMIT always opens a new packet; COMMIT lasts one cycle regardless.
    assign beat  = snoop_TVALID & snoop_TREADY;
    assign sop   = beat && ((state == ST_IDLE) || (state == ST_COMMIT));
    assign store = (sop && mem_ready) || (beat && (state == ST_CAPTURE) && !ptr_full);

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            ptr_full   <= 1'b0;
            acc_len    <= '0;
            acc_trunc  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_strb    <= '0;
            done       <= 1'b0;
            byte_len   <= '0;
            truncated  <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (store) begin
                wr_en   <= 1'b1;
                wr_addr <= sop ? '0 : wr_ptr;
                wr_data <= snoop_TDATA;
                wr_strb <= keep_vec;
            end

            // Report registers latch here so a new SOP in this same cycle cannot corrupt them.
            if (state == ST_COMMIT) begin
                done      <= 1'b1;
                byte_len  <= acc_len;
                truncated <= acc_trunc;
            end

            case (state)
                ST_IDLE, ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (beat) begin
                        if (state == ST_IDLE) begin
                            byte_len  <= '0;
                            truncated <= 1'b0;
                        end
                        if (mem_ready) begin
                            acc_len   <= `AXSNP_SAT_ADD(ZERO_LEN, keep_cnt, LEN_WIDTH);
                            acc_trunc <= 1'b0;
                            wr_ptr    <= ADDR_WIDTH'(1);
                            ptr_full  <= 1'b0;
                            state     <= snoop_TLAST ? ST_COMMIT : ST_CAPTURE;
                        end else begin
                            state <= snoop_TLAST ? ST_IDLE : ST_DISCARD;
                            if (snoop_TLAST) begin
                                drop_count <= `AXSNP_SAT_ADD(drop_count, 1'b1, DROP_CNT_WIDTH);
                            end
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (beat) begin
                        // Once the last address is used the pointer stays parked; later beats only flag truncation.
                        if (ptr_full) begin
                            acc_trunc <= 1'b1;
                        end else begin
                            acc_len <= `AXSNP_SAT_ADD(acc_len, keep_cnt, LEN_WIDTH);
                            wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                            if (&wr_ptr) begin
                                ptr_full <= 1'b1;
                            end
                        end
                        if (snoop_TLAST) begin
                            state <= ST_COMMIT;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (beat && snoop_TLAST) begin
                        state      <= ST_IDLE;
                        drop_count <= `AXSNP_SAT_ADD(drop_count, 1'b1, DROP_CNT_WIDTH);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_snooper_param.sv
// Self-checking bench for axis_snooper_param: two instances (deep memory, and 4-word memory with a 2-bit drop counter)
// share one randomized stream and are compared every cycle against a packet-level reference model.
module tb_axis_snooper_param;

    localparam int BPW = 8;

    logic        clk = 1'b0;
    logic        axiResetN;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        memReady;

    logic [8:0]  wrAddrA;
    logic [63:0] wrDataA;
    logic [7:0]  wrStrbA;
    logic        wrEnA;
    logic        doneA;
    logic [15:0] byteLenA;
    logic        truncA;
    logic [15:0] dropA;

    logic [1:0]  wrAddrB;
    logic [63:0] wrDataB;
    logic [7:0]  wrStrbB;
    logic        wrEnB;
    logic        doneB;
    logic [15:0] byteLenB;
    logic        truncB;
    logic [1:0]  dropB;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          inPkt;
        bit          capturing;
        int          idx;
        longint      acc;
        bit          accTr;
        bit          pend;
        longint      pendLen;
        bit          pendTr;
        longint      drop;
        bit          wrEn;
        longint      addr;
        logic [63:0] data;
        logic [7:0]  strb;
        bit          done;
        longint      len;
        bit          trunc;
        bit          rstNow;
    } model_t;

    model_t mA;
    model_t mB;

    always #5 clk = ~clk;

    axis_snooper_param #(
        .DATA_WIDTH(64), .ADDR_WIDTH(9), .LEN_WIDTH(16), .DROP_CNT_WIDTH(16)
    ) dutA (
        .axi_aclk     (clk),
        .axi_aresetn  (axiResetN),
        .snoop_TDATA  (tdata),
`ifdef SNOOP_TKEEP_EN
        .snoop_TKEEP  (tkeep),
`endif
        .snoop_TVALID (tvalid),
        .snoop_TREADY (tready),
        .snoop_TLAST  (tlast),
        .mem_ready    (memReady),
        .wr_addr      (wrAddrA),
        .wr_data      (wrDataA),
        .wr_strb      (wrStrbA),
        .wr_en        (wrEnA),
        .done         (doneA),
        .byte_len     (byteLenA),
        .truncated    (truncA),
        .drop_count   (dropA)
    );

    axis_snooper_param #(
        .DATA_WIDTH(64), .ADDR_WIDTH(2), .LEN_WIDTH(16), .DROP_CNT_WIDTH(2)
    ) dutB (
        .axi_aclk     (clk),
        .axi_aresetn  (axiResetN),
        .snoop_TDATA  (tdata),
`ifdef SNOOP_TKEEP_EN
        .snoop_TKEEP  (tkeep),
`endif
        .snoop_TVALID (tvalid),
        .snoop_TREADY (tready),
        .snoop_TLAST  (tlast),
        .mem_ready    (memReady),
        .wr_addr      (wrAddrB),
        .wr_data      (wrDataB),
        .wr_strb      (wrStrbB),
        .wr_en        (wrEnB),
        .done         (doneB),
        .byte_len     (byteLenB),
        .truncated    (truncB),
        .drop_count   (dropB)
    );

    // Packet-level reference: what the outputs must show right after the edge that sampled these inputs.
    function automatic model_t modelStep(model_t m, int aw, int lenw, int dropw,
                                         bit rstN, bit beat, bit last, bit mr,
                                         logic [63:0] d, logic [7:0] k);
        model_t      n;
        longint      lenMax;
        longint      dropMax;
        longint      depth;
        int          pop;
        logic [7:0]  strb;
        n       = m;
        lenMax  = (longint'(1) << lenw) - 1;
        dropMax = (longint'(1) << dropw) - 1;
        depth   = longint'(1) << aw;
`ifdef SNOOP_TKEEP_EN
        strb = k;
        pop  = $countones(k);
`else
        strb = 8'hFF;
        pop  = BPW;
`endif
        n.wrEn   = 1'b0;
        n.done   = 1'b0;
        n.rstNow = 1'b0;
        if (!rstN) begin
            n        = '{default: 0};
            n.rstNow = 1'b1;
            return n;
        end
        if (m.pend) begin
            n.done  = 1'b1;
            n.len   = m.pendLen;
            n.trunc = m.pendTr;
            n.pend  = 1'b0;
        end
        if (beat) begin
            if (!m.inPkt) begin
                if (!n.done) begin
                    n.len   = 0;
                    n.trunc = 1'b0;
                end
                n.inPkt     = 1'b1;
                n.capturing = mr;
                n.idx       = 0;
                n.acc       = 0;
                n.accTr     = 1'b0;
            end
            if (n.capturing) begin
                if (n.idx < depth) begin
                    n.wrEn = 1'b1;
                    n.addr = n.idx;
                    n.data = d;
                    n.strb = strb;
                    n.acc  = (n.acc + pop > lenMax) ? lenMax : n.acc + pop;
                end else begin
                    n.accTr = 1'b1;
                end
                n.idx = n.idx + 1;
            end
            if (last) begin
                n.inPkt = 1'b0;
                if (n.capturing) begin
                    n.pend    = 1'b1;
                    n.pendLen = n.acc;
                    n.pendTr  = n.accTr;
                end else begin
                    n.drop = (n.drop + 1 > dropMax) ? dropMax : n.drop + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic checkValue(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkInst(string p, model_t m, logic we, logic [63:0] addr, logic [63:0] data,
                             logic [7:0] strb, logic dn, logic [63:0] len, logic tr, logic [63:0] drop);
        checkValue({p, ".wr_en"},      64'(we),   64'(m.wrEn));
        checkValue({p, ".done"},       64'(dn),   64'(m.done));
        checkValue({p, ".byte_len"},   len,       64'(m.len));
        checkValue({p, ".truncated"},  64'(tr),   64'(m.trunc));
        checkValue({p, ".drop_count"}, drop,      64'(m.drop));
        if (m.wrEn || m.rstNow) begin
            checkValue({p, ".wr_addr"}, addr,       64'(m.addr));
            checkValue({p, ".wr_data"}, data,       m.data);
            checkValue({p, ".wr_strb"}, 64'(strb),  64'(m.strb));
        end
    endtask

    task automatic checkOutput();
        checkInst("A", mA, wrEnA, 64'(wrAddrA), wrDataA, wrStrbA, doneA, 64'(byteLenA), truncA, 64'(dropA));
        checkInst("B", mB, wrEnB, 64'(wrAddrB), wrDataB, wrStrbB, doneB, 64'(byteLenB), truncB, 64'(dropB));
    endtask

    task automatic applyStimulus(bit rN, bit v, bit r, bit l, bit mr, logic [7:0] k);
        logic [63:0] d;
        d         = {$urandom, $urandom};
        axiResetN = rN;
        tvalid    = v;
        tready    = r;
        tlast     = l;
        memReady  = mr;
        tdata     = d;
        tkeep     = k;
        @(posedge clk);
        mA = modelStep(mA, 9, 16, 16, rN, v & r, l, mr, d, k);
        mB = modelStep(mB, 2, 16, 2,  rN, v & r, l, mr, d, k);
        #1;
    endtask

    task automatic step(bit rN, bit v, bit r, bit l, bit mr, logic [7:0] k);
        applyStimulus(rN, v, r, l, mr, k);
        checkOutput();
    endtask

    task automatic sendBeat(bit last, logic [7:0] k, bit mr);
        step(1'b1, 1'b1, 1'b1, last, mr, k);
    endtask

    task automatic bubble();
        bit v;
        bit r;
        v = 1'($urandom_range(1));
        r = v ? 1'b0 : 1'($urandom_range(1));
        step(1'b1, v, r, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    endtask

    task automatic sendPacket(int n, bit mrSop, bit mrRest, logic [7:0] lastKeep, bit randKeep, int bubblePct);
        logic [7:0] k;
        for (int i = 0; i < n; i++) begin
            if (i != 0 && bubblePct != 0 && $urandom_range(99) < bubblePct) begin
                repeat ($urandom_range(1, 3)) bubble();
            end
            k = randKeep ? 8'($urandom) : 8'hFF;
            if (i == n - 1) k = lastKeep;
            sendBeat(i == n - 1, k, (i == 0) ? mrSop : mrRest);
        end
    endtask

    initial begin
        mA = '{default: 0};
        mB = '{default: 0};

        $display("[TB] reset");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        idle(2);

        $display("[TB] 4-beat packet, last keep 0x0F");
        sendPacket(4, 1'b1, 1'b1, 8'h0F, 1'b0, 0);
        idle(3);

        $display("[TB] dropped 3-beat packet, mem_ready raised mid-packet");
        sendPacket(3, 1'b0, 1'b1, 8'hFF, 1'b0, 0);
        idle(2);

        $display("[TB] 6-beat packet overflows the small memory");
        sendPacket(6, 1'b1, 1'b1, 8'hFF, 1'b0, 0);
        idle(3);

        $display("[TB] 4-beat packet with 5-cycle TREADY stall");
        sendBeat(1'b0, 8'hFF, 1'b1);
        sendBeat(1'b0, 8'hFF, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        sendBeat(1'b0, 8'hFF, 1'b0);
        sendBeat(1'b1, 8'h0F, 1'b0);
        idle(3);

        $display("[TB] back-to-back single-beat packets");
        sendBeat(1'b1, 8'hFF, 1'b1);
        sendBeat(1'b1, 8'hFF, 1'b1);
        idle(3);

        $display("[TB] drop counter saturation");
        repeat (5) sendBeat(1'b1, 8'hFF, 1'b0);
        sendPacket(3, 1'b0, 1'b1, 8'hFF, 1'b0, 0);
        idle(2);

        $display("[TB] reset mid-capture");
        sendBeat(1'b0, 8'hFF, 1'b1);
        sendBeat(1'b0, 8'hFF, 1'b1);
        sendBeat(1'b0, 8'hFF, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        sendBeat(1'b0, 8'hFF, 1'b1);
        sendBeat(1'b1, 8'h3C, 1'b1);
        idle(3);

        $display("[TB] randomized traffic");
        for (int p = 0; p < 60; p++) begin
            sendPacket($urandom_range(1, 7), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                       8'($urandom), 1'b1, 30);
            if ($urandom_range(24) == 0) begin
                step(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, 1'b1, 8'hFF);
            end
            if ($urandom_range(2) != 0) begin
                idle($urandom_range(1, 2));
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_snooper_param.md
Name: axis_snooper_param

Overview:
- Parametrised next-generation AXI Stream snooper for the packet filter.
- Passively observes a stream and cannot back-pressure it.
- Writes each accepted packet into packet memory at configurable data width, with byte strobes.
- Reports exact byte length and a truncation flag on completion; counts packets dropped because memory was not ready.

Parameters:
- DATA_WIDTH, 64, stream and memory word width in bits (8·2^k, 32..512).
- ADDR_WIDTH, 9, packet memory word-address width; capacity = 2^ADDR_WIDTH words.
- LEN_WIDTH, 16, width of byte-length output.
- DROP_CNT_WIDTH, 16, width of saturating drop counter.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  synchronous active-low reset.
- snoop_TDATA  in  DATA_WIDTH  observed data.
- snoop_TKEEP  in  DATA_WIDTH/8  observed byte keep (only with SNOOP_TKEEP_EN).
- snoop_TVALID  in  1  observed valid.
- snoop_TREADY  in  1  observed ready (input; block snoops).
- snoop_TLAST  in  1  observed last.
- mem_ready  in  1  packet memory free for a new packet.
- wr_addr  out  ADDR_WIDTH  word write address.
- wr_data  out  DATA_WIDTH  write data.
- wr_strb  out  DATA_WIDTH/8  byte write enables.
- wr_en  out  1  write strobe.
- done  out  1  one-cycle pulse, packet committed.
- byte_len  out  LEN_WIDTH  bytes captured; valid while done=1.
- truncated  out  1  packet exceeded memory; valid while done=1.
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped packets.

Behaviour:
- Beat = snoop_TVALID & snoop_TREADY sampled on rising edge; all other cycles ignored.
- Reset (sync, active-low, any state incl. mid-packet): every output 0, state IDLE. The next beat is treated as start-of-packet (SOP).
- States:
  - IDLE: on SOP beat with mem_ready=1 -> CAPTURE; with mem_ready=0 -> DISCARD.
  - CAPTURE: writes beats; on TLAST beat -> COMMIT.
  - DISCARD: writes nothing; on TLAST beat -> IDLE and drop_count+1, saturating at all-ones.
  - COMMIT: one cycle; done=1 -> IDLE.
- Single-beat packet (SOP with TLAST): IDLE -> COMMIT directly, or IDLE -> IDLE with a drop.
- mem_ready is sampled only at SOP. Deassertion mid-packet is ignored.
- Write path registered, latency 1:
  - beat n of a packet -> wr_en=1 next cycle, wr_addr=n, wr_data=TDATA, wr_strb=TKEEP.
  - wr_en is high exactly one cycle per written beat.
- byte_len accumulates popcount(wr_strb) per written beat and saturates at 2^LEN_WIDTH-1.
- done is asserted the cycle after the last wr_en, so the write is committed first. byte_len and truncated hold until the next SOP, then clear.
- Overflow: beat index ≥ 2^ADDR_WIDTH is not written and does not add to byte_len, and truncated is set. Capture continues until TLAST. wr_addr never wraps.
- Back-to-back packets: an SOP beat may arrive in the COMMIT cycle. It is evaluated against mem_ready that cycle, exactly as in IDLE.
- Bubbles (TVALID=0 or TREADY=0) inside a packet produce no writes and no state change.

Optional Feature:
- SNOOP_TKEEP_EN defined: snoop_TKEEP port present; wr_strb=TKEEP; byte_len counts kept bytes.
- Undefined: no TKEEP port; wr_strb all ones; byte_len = written beats × DATA_WIDTH/8; popcount logic omitted.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, CAPTURE, DISCARD, COMMIT);
  - BYTES_PER_WORD = DATA_WIDTH/8;
  - saturating-add helper macro.
- One sub-module: keep_popcount, a parametrised combinational/registered popcount of the keep vector, instantiated only under SNOOP_TKEEP_EN.

Test Plan:
- DATA_WIDTH=64, mem_ready=1, 4-beat packet, last TKEEP=0x0F -> wr_addr 0..3, one wr_en per beat; done one cycle after the 4th write; byte_len=28; truncated=0.
- mem_ready=0 at SOP of 3-beat packet, then raised mid-packet -> no wr_en, no done; drop_count 0->1.
- ADDR_WIDTH=2, 6-beat packet -> writes at addresses 0..3 only; done with byte_len=32 and truncated=1.
- TVALID high with TREADY low for 5 cycles inside a packet -> no writes during stall; final byte_len unchanged vs. unstalled run.
- Two 1-beat packets back-to-back, second SOP during COMMIT with mem_ready=1 -> two done pulses 1 cycle apart, each byte_len=8.
- axi_aresetn low for 1 cycle mid-CAPTURE -> all outputs 0 next cycle; next beat is captured as SOP at wr_addr 0; drop_count cleared to 0.
